// File: rtl/multiplexed_display_driver_if.sv
// Load handshake between the datapath output register and the display driver.
// The producer presents a packed word with load; pending reports an undisplayed capture.
interface multiplexed_display_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value_in;
  logic                  pending;

  modport master (
    output load,
    output value_in,
    input  pending
  );

  modport slave (
    input  load,
    input  value_in,
    output pending
  );
endinterface

// File: rtl/multiplexed_display_driver.sv
// Time-multiplexed 15-segment display driver with double-buffered load,
// leading-zero blanking and a minus glyph.
module multiplexed_display_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 blank_lz,
  multiplexed_display_driver_if.slave bus,
  output logic                 frame_start,
  output logic [DIGITS-1:0]    digit_enable,
  output logic [14:0]          segment_pattern
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [CW-1:0] PTOP = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] DTOP = IW'(DIGITS - 1);

  logic [VW-1:0]     pend_q, pend_d;
  logic [VW-1:0]     shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic [CW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              frame_q, frame_d;
  logic [DIGITS-1:0] den_q, den_d;
  logic [14:0]       seg_q, seg_d;

  logic              term;
  logic              last;
  logic              xfer;
  logic              run_zero;
  logic              blank;
  logic [3:0]        code;
  logic [DIGITS-1:0] lz;

  function automatic logic [14:0] glyph(input logic [3:0] c);
    logic [14:0] g;
    g = 15'h0000;
    case (c)
      4'h0:    g = 15'h0C3F;
      4'h1:    g = 15'h0406;
      4'h2:    g = 15'h00DB;
      4'h3:    g = 15'h00CF;
      4'h4:    g = 15'h00E6;
      4'h5:    g = 15'h00ED;
      4'h6:    g = 15'h00FD;
      4'h7:    g = 15'h1401;
      4'h8:    g = 15'h00FF;
      4'h9:    g = 15'h00EF;
      4'hF:    g = 15'h00C0;
      default: g = 15'h0000;
    endcase
    return g;
  endfunction

  always_comb begin
    term      = (presc_q == PTOP);
    last      = (idx_q == DTOP);
    // Swap only at a frame boundary so a frame never mixes two words
    xfer      = pending_q & (~enable | (term & last));
    pend_d    = bus.load ? bus.value_in : pend_q;
    shadow_d  = xfer ? pend_q : shadow_q;
    pending_d = bus.load | (pending_q & ~xfer);
    presc_d   = '0;
    idx_d     = '0;
    if (enable) begin
      presc_d = term ? '0 : presc_q + CW'(1);
      idx_d   = idx_q;
      if (term) begin
        idx_d = last ? '0 : idx_q + IW'(1);
      end
    end
  end

  always_comb begin
    run_zero = 1'b1;
    lz       = '0;
    code     = 4'h0;
    den_d    = '0;
    // A digit is a leading zero when it and every digit above it is 0
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run_zero = run_zero & (shadow_q[4*k +: 4] == 4'h0);
      lz[k]    = run_zero & (k != 0);
    end
    blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == idx_q) begin
        code     = shadow_q[4*k +: 4];
        blank    = blank_lz & lz[k];
        den_d[k] = enable;
      end
    end
    seg_d   = (enable && !blank) ? glyph(code) : 15'h0000;
    frame_d = enable & (presc_q == '0) & (idx_q == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      presc_q   <= '0;
      idx_q     <= '0;
      frame_q   <= 1'b0;
      den_q     <= '0;
      seg_q     <= '0;
    end else begin
      pend_q    <= pend_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      den_q     <= den_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.pending     = pending_q;
  assign frame_start     = frame_q;
  assign digit_enable    = den_q;
  assign segment_pattern = seg_q;

endmodule

// File: tb/tb_multiplexed_display_driver.sv
// Randomized bench for the display driver: two instances (4x4 and 1x1)
// compared cycle by cycle with a frame-position reference model.
module tb_multiplexed_display_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        en_a, blz_a, en_b, blz_b;
  logic        fs_a, fs_b;
  logic [3:0]  den_a;
  logic [0:0]  den_b;
  logic [14:0] seg_a, seg_b;

  int n_chk = 0;
  int n_err = 0;

  multiplexed_display_driver_if #(.DIGITS(4)) bus_a();
  multiplexed_display_driver_if #(.DIGITS(1)) bus_b();

  multiplexed_display_driver #(.DIGITS(4), .PRESCALE(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .blank_lz(blz_a),
    .bus(bus_a.slave), .frame_start(fs_a),
    .digit_enable(den_a), .segment_pattern(seg_a)
  );

  multiplexed_display_driver #(.DIGITS(1), .PRESCALE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .blank_lz(blz_b),
    .bus(bus_b.slave), .frame_start(fs_b),
    .digit_enable(den_b), .segment_pattern(seg_b)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        pend;
    logic [31:0] pv;
    logic [31:0] sh;
  } mst_t;

  mst_t ma, mb;

  function automatic logic [14:0] glyph_ref(input logic [3:0] c);
    case (c)
      4'h0: return 15'h0C3F;
      4'h1: return 15'h0406;
      4'h2: return 15'h00DB;
      4'h3: return 15'h00CF;
      4'h4: return 15'h00E6;
      4'h5: return 15'h00ED;
      4'h6: return 15'h00FD;
      4'h7: return 15'h1401;
      4'h8: return 15'h00FF;
      4'h9: return 15'h00EF;
      4'hF: return 15'h00C0;
      default: return 15'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // s = enabled edges since reset or last disable; frame position is s mod D*P
  task automatic model(input int d, input int p, input mst_t i,
                       input logic en, input logic ld,
                       input logic [31:0] v, input logic blz,
                       output mst_t o, output logic [31:0] den,
                       output logic [31:0] seg, output logic fs);
    int pos, dig;
    logic xf;
    logic [31:0] above;
    o = i; den = 0; seg = 0; fs = 0; xf = 0;
    if (en) begin
      pos   = int'(i.s % 32'(d * p));
      dig   = pos / p;
      den   = 32'd1 << dig;
      fs    = (pos == 0);
      above = i.sh >> (4 * dig);
      if (blz && dig > 0 && above == 0) seg = 0;
      else seg = 32'(glyph_ref(above[3:0]));
      xf    = (pos == d * p - 1);
      o.s   = i.s + 1;
    end else begin
      o.s = 0;
      xf  = 1'b1;
    end
    if (xf && i.pend) begin
      o.sh   = i.pv;
      o.pend = 1'b0;
    end
    if (ld) begin
      o.pv   = v;
      o.pend = 1'b1;
    end
  endtask

  task automatic step();
    logic [31:0] da, sa, db, sb;
    logic fa, fb;
    model(4, 4, ma, en_a, bus_a.load, 32'(bus_a.value_in), blz_a,
          ma, da, sa, fa);
    model(1, 1, mb, en_b, bus_b.load, 32'(bus_b.value_in), blz_b,
          mb, db, sb, fb);
    @(posedge clk);
    #1;
    chk("den_a", 32'(den_a), da);
    chk("seg_a", 32'(seg_a), sa);
    chk("fs_a", 32'(fs_a), 32'(fa));
    chk("pend_a", 32'(bus_a.pending), 32'(ma.pend));
    chk("den_b", 32'(den_b), db);
    chk("seg_b", 32'(seg_b), sb);
    chk("fs_b", 32'(fs_b), 32'(fb));
    chk("pend_b", 32'(bus_b.pending), 32'(mb.pend));
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic ld,
                       input logic [15:0] v, input logic blz);
    en_a = en; bus_a.load = ld; bus_a.value_in = v; blz_a = blz;
    en_b = en; bus_b.load = ld; bus_b.value_in = v[3:0]; blz_b = blz;
  endtask

  task automatic run(input int n);
    bus_a.load = 1'b0;
    bus_b.load = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic put(input logic [15:0] v, input logic blz);
    drive(1'b1, 1'b1, v, blz);
    step();
    bus_a.load = 1'b0;
    bus_b.load = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_den_a", 32'(den_a), 0);
    chk("rst_seg_a", 32'(seg_a), 0);
    chk("rst_fs_a", 32'(fs_a), 0);
    chk("rst_pend_a", 32'(bus_a.pending), 0);
    chk("rst_den_b", 32'(den_b), 0);
    chk("rst_fs_b", 32'(fs_b), 0);
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      en_a = ($urandom_range(0, 19) != 0);
      bus_a.load = ($urandom_range(0, 9) == 0);
      bus_a.value_in = 16'($urandom);
      if ($urandom_range(0, 2) == 0) bus_a.value_in[15:8] = 8'h00;
      blz_a = 1'($urandom);
      en_b = ($urandom_range(0, 9) != 0);
      bus_b.load = ($urandom_range(0, 3) == 0);
      bus_b.value_in = 4'($urandom);
      blz_b = 1'($urandom);
      step();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    ma = '0;
    mb = '0;
    repeat (3) @(negedge clk);
    chk_reset();
    reset_n = 1'b1;
    run(6);

    put(16'h1234, 1'b0);
    run(40);
    run(5);
    put(16'h5678, 1'b0);
    run(36);

    put(16'h0070, 1'b1);
    run(36);
    put(16'h0000, 1'b1);
    run(36);
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    run(20);
    put(16'hFABC, 1'b0);
    run(36);

    for (int i = 0; i < 20 && ma.s % 16 != 15; i++) run(1);
    put(16'h9999, 1'b0);
    run(36);

    put(16'h2468, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    run(3);
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    run(20);

    rand_run(2000);

    reset_n = 1'b0;
    #1;
    chk_reset();
    ma = '0;
    mb = '0;
    @(negedge clk);
    reset_n = 1'b1;
    rand_run(500);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
